wordle_score_history: RTL and testbench

Parametrised guess scoring and board-history engine for the Wordle design. It accepts one guess per handshake and scores it against a latched secret word with correct duplicate-letter handling: greens are found first, then yellows consume only unmatched secret letters. Each scored row is stored in an on-chip board history. A registered random-access read port feeds the VGA renderer. It replaces the fixed 5×6, negedge-driven history/colour logic in the top level with a single `board_clk` synchronous block.

---
 rtl/wordle_pkg.sv | 19 +
 rtl/wordle_yellow_finder.sv | 32 +++
 rtl/wordle_score_history.sv | 196 +++++++++++++++++++
 tb/tb_wordle_score_history.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wordle_pkg.sv
// Shared definitions for the Wordle scoring engine.
// Holds the board colour codes, the blank-cell letter and the scoring FSM states.
package wordle_pkg;

    localparam logic [1:0] COL_EMPTY   = 2'd0;
    localparam logic [1:0] COL_ABSENT  = 2'd1;
    localparam logic [1:0] COL_PRESENT = 2'd2;
    localparam logic [1:0] COL_CORRECT = 2'd3;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/wordle_yellow_finder.sv
// Finds the lowest-index secret position holding g_letter that is not yet used.
// Ports:
//   g_letter   - guess letter being scored
//   secret     - secret word, letter 0 in the MSBs
//   used       - one bit per secret position already matched
//   found_c    - a free matching position exists
//   j_onehot_c - one-hot marker of that position (zero when not found)
module wordle_yellow_finder #(
    parameter int unsigned WORD_LEN = 5,
    parameter int unsigned CHAR_W   = 8
) (
    input  logic [CHAR_W-1:0]          g_letter,
    input  logic [WORD_LEN*CHAR_W-1:0] secret,
    input  logic [WORD_LEN-1:0]        used,
    output logic                       found_c,
    output logic [WORD_LEN-1:0]        j_onehot_c
);

    // Priority scan: the first hit blocks all higher positions.
    always_comb begin
        found_c    = 1'b0;
        j_onehot_c = '0;
        for (int j = 0; j < WORD_LEN; j++) begin
            if (!found_c && !used[j] &&
                secret[(WORD_LEN-1-j)*CHAR_W +: CHAR_W] == g_letter) begin
                found_c       = 1'b1;
                j_onehot_c[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wordle_score_history.sv
// Guess scoring and board history for the Wordle game.
// Scores one latched guess against a latched secret (greens first, then yellows
// that consume only unmatched secret letters) and stores each row for display.
// Ports:
//   board_clk, reset             - clock, async active-high reset
//   clear                        - synchronous new game, aborts scoring
//   secret, guess, guess_valid   - guess handshake (letter 0 in MSBs)
//   guess_ready, busy            - handshake / scoring status
//   score_done, win, lose        - row commit pulse and game result
//   guess_count                  - rows committed
//   rd_row, rd_col               - board read address
//   rd_char, rd_color            - board read data, one cycle after address
module wordle_score_history
    import wordle_pkg::*;
#(
    parameter  int unsigned WORD_LEN    = 5,
    parameter  int unsigned MAX_GUESSES = 6,
    parameter  int unsigned CHAR_W      = 8,
    localparam int unsigned ROW_W       = $clog2(MAX_GUESSES),
    localparam int unsigned COL_W       = $clog2(WORD_LEN),
    localparam int unsigned CNT_W       = $clog2(MAX_GUESSES + 1)
) (
    input  logic                       board_clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WORD_LEN*CHAR_W-1:0] secret,
    input  logic [WORD_LEN*CHAR_W-1:0] guess,
    input  logic                       guess_valid,
    output logic                       guess_ready,
    output logic                       busy,
    output logic                       score_done,
    output logic                       win,
    output logic                       lose,
    output logic [CNT_W-1:0]           guess_count,
    input  logic [ROW_W-1:0]           rd_row,
    input  logic [COL_W-1:0]           rd_col,
    output logic [CHAR_W-1:0]          rd_char,
    output logic [1:0]                 rd_color
);

    localparam int unsigned        WORD_W = WORD_LEN * CHAR_W;
    localparam logic [CHAR_W-1:0]  SPACE  = CHAR_W'(ASCII_SPACE);

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     secret_q;
    logic [CHAR_W-1:0]     guess_q [WORD_LEN];
    logic [WORD_LEN-1:0]   green_q, used_q, green_c, j_onehot_c;
    logic                  found_c, accept_c, last_col_c;
    logic [COL_W-1:0]      col_q;
    logic [1:0]            color_q [WORD_LEN];
    logic [CHAR_W-1:0]     board_char  [MAX_GUESSES][WORD_LEN];
    logic [1:0]            board_color [MAX_GUESSES][WORD_LEN];

    // Per-column exact matches against the latched words.
    always_comb begin
        green_c = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            green_c[i] = (guess_q[i] == secret_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W]);
        end
    end

    assign accept_c   = guess_valid && guess_ready && !clear;
    assign last_col_c = (col_q == COL_W'(WORD_LEN - 1));

    wordle_yellow_finder #(
        .WORD_LEN (WORD_LEN),
        .CHAR_W   (CHAR_W)
    ) u_yellow_finder (
        .g_letter   (guess_q[col_q]),
        .secret     (secret_q),
        .used       (used_q),
        .found_c    (found_c),
        .j_onehot_c (j_onehot_c)
    );

    // State register.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (accept_c) state_d = ST_GREEN;
                ST_GREEN:  state_d = ST_YELLOW;
                ST_YELLOW: if (last_col_c) state_d = ST_COMMIT;
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        guess_ready = 1'b0;
        busy        = 1'b0;
        if (state_q == ST_IDLE) guess_ready = !win && !lose;
        else                    busy        = 1'b1;
    end

    // Scoring datapath and board storage; the board is only written in COMMIT.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            secret_q    <= '0;
            green_q     <= '0;
            used_q      <= '0;
            col_q       <= '0;
            guess_count <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            score_done  <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++) begin
                guess_q[i] <= '0;
                color_q[i] <= COL_EMPTY;
            end
            for (int r = 0; r < MAX_GUESSES; r++) begin
                for (int c = 0; c < WORD_LEN; c++) begin
                    board_char[r][c]  <= SPACE;
                    board_color[r][c] <= COL_EMPTY;
                end
            end
        end else begin
            score_done <= 1'b0;
            if (clear) begin
                guess_count <= '0;
                win         <= 1'b0;
                lose        <= 1'b0;
                for (int r = 0; r < MAX_GUESSES; r++) begin
                    for (int c = 0; c < WORD_LEN; c++) begin
                        board_char[r][c]  <= SPACE;
                        board_color[r][c] <= COL_EMPTY;
                    end
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept_c) begin
                            secret_q <= secret;
                            for (int i = 0; i < WORD_LEN; i++) begin
                                guess_q[i] <= guess[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
                            end
                        end
                    end
                    ST_GREEN: begin
                        green_q <= green_c;
                        used_q  <= green_c;
                        col_q   <= '0;
                    end
                    ST_YELLOW: begin
                        if (green_q[col_q]) begin
                            color_q[col_q] <= COL_CORRECT;
                        end else if (found_c) begin
                            color_q[col_q] <= COL_PRESENT;
                            used_q         <= used_q | j_onehot_c;
                        end else begin
                            color_q[col_q] <= COL_ABSENT;
                        end
                        col_q <= col_q + COL_W'(1);
                    end
                    ST_COMMIT: begin
                        for (int i = 0; i < WORD_LEN; i++) begin
                            board_char[ROW_W'(guess_count)][i]  <= guess_q[i];
                            board_color[ROW_W'(guess_count)][i] <= color_q[i];
                        end
                        guess_count <= guess_count + CNT_W'(1);
                        score_done  <= 1'b1;
                        win         <= &green_q;
                        lose        <= !(&green_q) &&
                                       (32'(guess_count) + 32'd1 == MAX_GUESSES);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered read port; out-of-range addresses read as an empty cell.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            rd_char  <= SPACE;
            rd_color <= COL_EMPTY;
        end else if (32'(rd_row) < MAX_GUESSES && 32'(rd_col) < WORD_LEN) begin
            rd_char  <= board_char[rd_row][rd_col];
            rd_color <= board_color[rd_row][rd_col];
        end else begin
            rd_char  <= SPACE;
            rd_color <= COL_EMPTY;
        end
    end

endmodule

// File: tb/tb_wordle_score_history.sv
// Scoreboard bench for wordle_score_history: stimulus pushes expected commit
// results and read data into queues, monitors pop and compare on DUT outputs.
module tb_wordle_score_history;
    import wordle_pkg::*;

    localparam int unsigned WORD_LEN    = 5;
    localparam int unsigned MAX_GUESSES = 6;
    localparam int unsigned CHAR_W      = 8;

    logic        board_clk = 1'b0;
    logic        reset, clear, guess_valid;
    logic [39:0] secret, guess;
    logic        guess_ready, busy, score_done, win, lose;
    logic [2:0]  guess_count;
    logic [2:0]  rd_row, rd_col;
    logic [7:0]  rd_char;
    logic [1:0]  rd_color;

    always #5 board_clk = ~board_clk;

    wordle_score_history #(
        .WORD_LEN    (WORD_LEN),
        .MAX_GUESSES (MAX_GUESSES),
        .CHAR_W      (CHAR_W)
    ) dut (
        .board_clk   (board_clk),
        .reset       (reset),
        .clear       (clear),
        .secret      (secret),
        .guess       (guess),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .busy        (busy),
        .score_done  (score_done),
        .win         (win),
        .lose        (lose),
        .guess_count (guess_count),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_char     (rd_char),
        .rd_color    (rd_color)
    );

    typedef struct { int cnt; bit win; bit lose; } sd_exp_t;
    typedef struct { logic [7:0] ch; logic [1:0] col; } rd_exp_t;

    sd_exp_t sd_q[$];
    rd_exp_t rd_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic rd_req = 1'b0;
    logic rd_req_q = 1'b0;

    always @(posedge board_clk) begin
        cyc      <= cyc + 1;
        rd_req_q <= rd_req;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: commit results and read data.
    always @(negedge board_clk) begin
        sd_exp_t e;
        rd_exp_t r;
        if (score_done) begin
            if (sd_q.size() == 0) begin
                check("unexpected_score_done", 64'(score_done), 64'd0);
            end else begin
                e = sd_q.pop_front();
                check("guess_count", 64'(guess_count), 64'(e.cnt));
                check("win", 64'(win), 64'(e.win));
                check("lose", 64'(lose), 64'(e.lose));
                check("latency", 64'(cyc - accept_cyc + 1), 64'd8);
            end
        end
        if (rd_req_q) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", 64'(rd_req_q), 64'd0);
            end else begin
                r = rd_q.pop_front();
                check("rd_char", 64'(rd_char), 64'(r.ch));
                check("rd_color", 64'(rd_color), 64'(r.col));
            end
        end
    end

    task automatic submit(input logic [39:0] s, input logic [39:0] g, input bit expect_it,
                          input int ecnt, input bit ewin, input bit elose);
        int t;
        sd_exp_t e;
        t = 0;
        @(negedge board_clk);
        while (!guess_ready && t < 40) begin
            @(negedge board_clk);
            t++;
        end
        if (!guess_ready) begin
            check("ready_timeout", 64'(guess_ready), 64'd1);
            return;
        end
        secret      = s;
        guess       = g;
        guess_valid = 1'b1;
        if (expect_it) begin
            e.cnt = ecnt; e.win = ewin; e.lose = elose;
            sd_q.push_back(e);
        end
        @(posedge board_clk);
        #1;
        accept_cyc  = cyc;
        guess_valid = 1'b0;
        secret      = "QQQQQ";
        guess       = "QQQQQ";
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sd_q.size() != 0 && t < 40) begin
            @(negedge board_clk);
            t++;
        end
        check("score_done_timeout", 64'(sd_q.size()), 64'd0);
    endtask

    task automatic read_cell(input logic [2:0] row, input logic [2:0] col,
                             input logic [7:0] ch, input logic [1:0] colr);
        rd_exp_t r;
        @(negedge board_clk);
        rd_row = row;
        rd_col = col;
        r.ch = ch; r.col = colr;
        rd_q.push_back(r);
        rd_req = 1'b1;
        @(negedge board_clk);
        rd_req = 1'b0;
    endtask

    task automatic read_row(input logic [2:0] row, input logic [39:0] letters,
                            input logic [9:0] cols);
        for (int c = 0; c < 5; c++) begin
            read_cell(row, 3'(c), letters[(4-c)*8 +: 8], cols[(4-c)*2 +: 2]);
        end
    endtask

    task automatic pulse_clear();
        @(negedge board_clk);
        clear = 1'b1;
        @(negedge board_clk);
        clear = 1'b0;
    endtask

    // Offer a guess for n cycles while the block must not accept it.
    task automatic offer_ignored(input logic [39:0] s, input logic [39:0] g, input int n);
        @(negedge board_clk);
        secret = s; guess = g; guess_valid = 1'b1;
        repeat (n) @(negedge board_clk);
        guess_valid = 1'b0;
        check("busy_after_ignored", 64'(busy), 64'd0);
        repeat (12) @(negedge board_clk);
    endtask

    localparam logic [9:0] ALL_CORRECT = 10'h3FF;
    localparam logic [9:0] ALL_ABSENT  = 10'b01_01_01_01_01;
    localparam logic [9:0] ALL_EMPTY   = 10'h000;
    localparam logic [39:0] SPACES     = "     ";

    initial begin
        reset = 1'b1; clear = 1'b0; guess_valid = 1'b0;
        secret = '0; guess = '0; rd_row = '0; rd_col = '0;
        repeat (3) @(negedge board_clk);
        reset = 1'b0;
        @(negedge board_clk);

        check("rst_guess_ready", 64'(guess_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_score_done", 64'(score_done), 64'd0);
        check("rst_win", 64'(win), 64'd0);
        check("rst_lose", 64'(lose), 64'd0);
        check("rst_guess_count", 64'(guess_count), 64'd0);
        check("rst_rd_char", 64'(rd_char), 64'h20);
        check("rst_rd_color", 64'(rd_color), 64'd0);

        // Exact match wins on the first guess.
        submit("CRANE", "CRANE", 1, 1, 1, 0);
        @(negedge board_clk);
        check("busy_during_scoring", 64'(busy), 64'd1);
        check("ready_during_scoring", 64'(guess_ready), 64'd0);
        wait_done();
        @(negedge board_clk);
        check("ready_after_win", 64'(guess_ready), 64'd0);
        read_row(3'd0, "CRANE", ALL_CORRECT);
        read_cell(3'd1, 3'd0, 8'h20, COL_EMPTY);
        offer_ignored("CRANE", "SLATE", 4);
        check("count_after_win_block", 64'(guess_count), 64'd1);

        // New game, duplicate letters where yellows consume free letters only.
        pulse_clear();
        check("clear_win", 64'(win), 64'd0);
        check("clear_count", 64'(guess_count), 64'd0);
        check("clear_ready", 64'(guess_ready), 64'd1);
        read_row(3'd0, SPACES, ALL_EMPTY);
        submit("APPLE", "PAPER", 1, 1, 0, 0);
        wait_done();
        read_row(3'd0, "PAPER", 10'b10_10_11_10_01);
        read_cell(3'd0, 3'd2, "P", COL_CORRECT);
        read_cell(3'd6, 3'd0, 8'h20, COL_EMPTY);
        read_cell(3'd0, 3'd5, 8'h20, COL_EMPTY);
        read_cell(3'd7, 3'd7, 8'h20, COL_EMPTY);

        // Clear during YELLOW aborts the second row and empties the board.
        submit("APPLE", "PLANT", 0, 0, 0, 0);
        repeat (3) @(posedge board_clk);
        pulse_clear();
        check("abort_ready", 64'(guess_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_count", 64'(guess_count), 64'd0);
        repeat (12) @(negedge board_clk);
        read_cell(3'd0, 3'd2, 8'h20, COL_EMPTY);
        read_cell(3'd1, 3'd0, 8'h20, COL_EMPTY);

        // Clear together with a valid guess drops the guess.
        @(negedge board_clk);
        secret = "APPLE"; guess = "APPLE"; guess_valid = 1'b1; clear = 1'b1;
        @(negedge board_clk);
        guess_valid = 1'b0; clear = 1'b0;
        check("clear_wins_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge board_clk);
        check("clear_wins_count", 64'(guess_count), 64'd0);
        check("clear_wins_win", 64'(win), 64'd0);

        // Six misses lose the game.
        submit("ROBOT", "OOOOO", 1, 1, 0, 0); wait_done();
        submit("ROBOT", "AAAAA", 1, 2, 0, 0); wait_done();
        submit("ROBOT", "TOBOR", 1, 3, 0, 0); wait_done();
        submit("ROBOT", "ZZZZZ", 1, 4, 0, 0); wait_done();
        submit("ROBOT", "XXXXX", 1, 5, 0, 0); wait_done();
        submit("ROBOT", "YYYYY", 1, 6, 0, 1); wait_done();
        @(negedge board_clk);
        check("ready_after_lose", 64'(guess_ready), 64'd0);
        offer_ignored("ROBOT", "ROBOT", 4);
        check("count_after_lose_block", 64'(guess_count), 64'd6);
        check("win_after_lose_block", 64'(win), 64'd0);
        read_row(3'd0, "OOOOO", 10'b01_11_01_11_01);
        read_row(3'd2, "TOBOR", 10'b10_11_11_11_10);
        read_row(3'd5, "YYYYY", ALL_ABSENT);

        repeat (3) @(negedge board_clk);
        check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        check("sd_queue_drained", 64'(sd_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
